dmem_arbiter: RTL and testbench

- Shares the single data-memory port between the CPU load/store path and an auxiliary requester (debug loader / DMA) using a valid/ready handshake.
- Sits between `cpu`, the aux master and `data_mem`.
- Drives the CPU stall that gates the processor clock while the CPU is waiting or has been pre-empted.
- CPU has priority. A starvation limit guarantees the aux requester is granted.

---
 rtl/dmem_arbiter.sv | 172 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: shares one data_mem port between the CPU
// load/store path (priority) and an auxiliary valid/ready requester.
// A saturating starvation counter forces the aux requester in after
// MAX_CPU_BURST back-to-back CPU grants that found aux_valid pending.
module dmem_arbiter #(
  parameter int MAX_CPU_BURST = 4  // legal range 1..15
) (
  input  logic        clk,
  input  logic        reset,
  // CPU load/store path
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_memread,
  input  logic        cpu_memwrite,
  input  logic [2:0]  cpu_sign_mask,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  // auxiliary requester (debug loader / DMA)
  input  logic        aux_valid,
  input  logic        aux_we,
  input  logic [31:0] aux_addr,
  input  logic [31:0] aux_wdata,
  input  logic [2:0]  aux_sign_mask,
  output logic        aux_ready,
  output logic        aux_rvalid,
  output logic [31:0] aux_rdata,
  // data memory port
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_memread,
  output logic        mem_memwrite,
  output logic [2:0]  mem_sign_mask,
  input  logic [31:0] mem_rdata,
  input  logic        mem_busy
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CPU_ACC = 2'd1;
  localparam logic [1:0] ST_AUX_ACC = 2'd2;

  localparam logic [3:0] BURST_LIMIT = 4'(MAX_CPU_BURST);

  logic [1:0]  state_q, state_d;
  logic [3:0]  starve_q, starve_d;
  logic        aux_rvalid_q, aux_rvalid_d;
  logic [31:0] aux_rdata_q, aux_rdata_d;

  // Registered aux request, held for the whole AUX_ACC access
  logic        aux_load;
  logic        aux_we_q;
  logic [31:0] aux_addr_q;
  logic [31:0] aux_wdata_q;
  logic [2:0]  aux_mask_q;

  logic cpu_req;
  logic aux_force;

  assign cpu_req   = cpu_memread | cpu_memwrite;
  assign aux_force = aux_valid & (starve_q >= BURST_LIMIT);

  // The CPU always sees the memory read bus; it is only meaningful when its
  // own access completes, and the stall hides every other cycle.
  assign cpu_rdata  = mem_rdata;
  assign aux_rvalid = aux_rvalid_q;
  assign aux_rdata  = aux_rdata_q;

  // Grant decision, memory-port mux and next-state logic
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case can leave one unassigned and infer a latch.
    state_d       = state_q;
    starve_d      = starve_q;
    aux_rvalid_d  = 1'b0;
    aux_rdata_d   = aux_rdata_q;
    aux_load      = 1'b0;
    aux_ready     = 1'b0;
    cpu_stall     = 1'b0;
    mem_addr      = cpu_addr;
    mem_wdata     = cpu_wdata;
    mem_sign_mask = cpu_sign_mask;
    mem_memread   = 1'b0;
    mem_memwrite  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cpu_req && !aux_force) begin
          // CPU passes straight through: no added latency
          mem_memread  = cpu_memread;
          mem_memwrite = cpu_memwrite;
          cpu_stall    = mem_busy;
          if (mem_busy) state_d = ST_CPU_ACC;
          if (aux_valid) begin
            starve_d = (starve_q == 4'hF) ? 4'hF : starve_q + 4'd1;
          end else begin
            starve_d = 4'd0;
          end
        end else if (aux_valid) begin
          // Accept the aux request; the access itself goes out next cycle
          aux_ready = 1'b1;
          cpu_stall = 1'b1;
          aux_load  = 1'b1;
          starve_d  = 4'd0;
          state_d   = ST_AUX_ACC;
        end else begin
          starve_d = 4'd0;
        end
      end

      ST_CPU_ACC: begin
        mem_memread  = cpu_memread;
        mem_memwrite = cpu_memwrite;
        cpu_stall    = mem_busy;
        if (!mem_busy) state_d = ST_IDLE;
      end

      ST_AUX_ACC: begin
        mem_addr      = aux_addr_q;
        mem_wdata     = aux_wdata_q;
        mem_sign_mask = aux_mask_q;
        mem_memwrite  = aux_we_q;
        mem_memread   = ~aux_we_q;
        cpu_stall     = 1'b1;
        if (!mem_busy) begin
          // Captured for writes too, so aux_rdata always tracks the last completion
          aux_rdata_d  = mem_rdata;
          aux_rvalid_d = 1'b1;
          state_d      = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Nothing is granted or issued while reset is held
    if (reset) begin
      aux_ready    = 1'b0;
      cpu_stall    = 1'b0;
      mem_memread  = 1'b0;
      mem_memwrite = 1'b0;
    end
  end

  // Control state with synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q      <= ST_IDLE;
      starve_q     <= 4'd0;
      aux_rvalid_q <= 1'b0;
      aux_rdata_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      aux_rvalid_q <= aux_rvalid_d;
      aux_rdata_q  <= aux_rdata_d;
    end
  end

  // Aux request payload, loaded on the grant cycle
  always_ff @(posedge clk) begin
    // NOTE: payload registers are not reset; they are only observed in
    // AUX_ACC, which is always entered through a load.
    if (aux_load) begin
      aux_we_q    <= aux_we;
      aux_addr_q  <= aux_addr;
      aux_wdata_q <= aux_wdata;
      aux_mask_q  <= aux_sign_mask;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter (MAX_CPU_BURST = 4).
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge of the same cycle.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_memread, cpu_memwrite, cpu_stall;
  logic [2:0]  cpu_sign_mask;
  logic        aux_valid, aux_we, aux_ready, aux_rvalid;
  logic [31:0] aux_addr, aux_wdata, aux_rdata;
  logic [2:0]  aux_sign_mask;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_memread, mem_memwrite, mem_busy;
  logic [2:0]  mem_sign_mask;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.MAX_CPU_BURST(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_memread  (cpu_memread),
    .cpu_memwrite (cpu_memwrite),
    .cpu_sign_mask(cpu_sign_mask),
    .cpu_rdata    (cpu_rdata),
    .cpu_stall    (cpu_stall),
    .aux_valid    (aux_valid),
    .aux_we       (aux_we),
    .aux_addr     (aux_addr),
    .aux_wdata    (aux_wdata),
    .aux_sign_mask(aux_sign_mask),
    .aux_ready    (aux_ready),
    .aux_rvalid   (aux_rvalid),
    .aux_rdata    (aux_rdata),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_memread  (mem_memread),
    .mem_memwrite (mem_memwrite),
    .mem_sign_mask(mem_sign_mask),
    .mem_rdata    (mem_rdata),
    .mem_busy     (mem_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clr_inputs();
    cpu_addr = '0; cpu_wdata = '0; cpu_memread = 0; cpu_memwrite = 0; cpu_sign_mask = '0;
    aux_valid = 0; aux_we = 0; aux_addr = '0; aux_wdata = '0; aux_sign_mask = '0;
    mem_rdata = '0; mem_busy = 0;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    clr_inputs();
    reset = 1;
    next_cycle();
    next_cycle();

    // ---- reset gating: requests present while reset is held
    cpu_memread = 1; aux_valid = 1;
    sample();
    check("rst_aux_ready", aux_ready, 0);
    check("rst_cpu_stall", cpu_stall, 0);
    check("rst_memread", mem_memread, 0);
    check("rst_memwrite", mem_memwrite, 0);
    check("rst_rvalid", aux_rvalid, 0);
    check("rst_rdata", aux_rdata, 0);
    next_cycle();
    reset = 0;

    // ---- 1: CPU read, zero latency
    clr_inputs();
    cpu_memread = 1; cpu_addr = 32'h1000; mem_rdata = 32'hDEADBEEF;
    sample();
    check("t1_mem_addr", mem_addr, 32'h1000);
    check("t1_memread", mem_memread, 1);
    check("t1_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
    check("t1_stall", cpu_stall, 0);
    check("t1_aux_ready", aux_ready, 0);
    next_cycle();

    // ---- 2: CPU write, mem_busy for 3 cycles, aux waits
    clr_inputs();
    cpu_memwrite = 1; cpu_addr = 32'h1100; cpu_wdata = 32'hCAFE0001; cpu_sign_mask = 3'b010;
    aux_valid = 1; aux_we = 0; aux_addr = 32'h3000;
    mem_busy = 1;
    for (int i = 0; i < 3; i++) begin
      sample();
      check($sformatf("t2_stall%0d", i), cpu_stall, 1);
      check($sformatf("t2_addr%0d", i), mem_addr, 32'h1100);
      check($sformatf("t2_wdata%0d", i), mem_wdata, 32'hCAFE0001);
      check($sformatf("t2_memwrite%0d", i), mem_memwrite, 1);
      check($sformatf("t2_aux_ready%0d", i), aux_ready, 0);
      next_cycle();
    end
    mem_busy = 0;
    sample();
    check("t2_done_stall", cpu_stall, 0);
    check("t2_done_memwrite", mem_memwrite, 1);
    check("t2_done_aux_ready", aux_ready, 0);
    next_cycle();
    cpu_memwrite = 0;  // CPU moves on; pending aux now wins
    sample();
    check("t2_aux_ready", aux_ready, 1);
    check("t2_grant_stall", cpu_stall, 1);
    check("t2_grant_memread", mem_memread, 0);
    next_cycle();
    aux_valid = 0; mem_rdata = 32'h12345678;
    sample();
    check("t2_aux_memread", mem_memread, 1);
    check("t2_aux_addr", mem_addr, 32'h3000);
    next_cycle();
    sample();
    check("t2_rvalid", aux_rvalid, 1);
    check("t2_rdata", aux_rdata, 32'h12345678);
    next_cycle();

    // ---- 3: aux write alone, then back-to-back aux read
    clr_inputs();
    aux_valid = 1; aux_we = 1; aux_addr = 32'h2004; aux_wdata = 32'h55; aux_sign_mask = 3'b010;
    sample();
    check("t3_ready", aux_ready, 1);
    check("t3_grant_memwrite", mem_memwrite, 0);
    check("t3_grant_memread", mem_memread, 0);
    check("t3_grant_stall", cpu_stall, 1);
    next_cycle();
    aux_valid = 0; aux_addr = 32'hFFFF_FFFF; aux_wdata = 32'hFFFF_FFFF; aux_sign_mask = 3'b111;
    mem_rdata = 32'hAAAA0000;
    sample();
    check("t3_memwrite", mem_memwrite, 1);
    check("t3_memread", mem_memread, 0);
    check("t3_addr", mem_addr, 32'h2004);
    check("t3_wdata", mem_wdata, 32'h55);
    check("t3_mask", {29'd0, mem_sign_mask}, 32'd2);
    check("t3_rvalid_early", aux_rvalid, 0);
    next_cycle();
    aux_valid = 1; aux_we = 0; aux_addr = 32'h2008;
    sample();
    check("t3_rvalid", aux_rvalid, 1);
    check("t3_rdata_wr", aux_rdata, 32'hAAAA0000);
    check("t3_b2b_ready", aux_ready, 1);
    next_cycle();
    aux_valid = 0; mem_rdata = 32'h0BADF00D;
    sample();
    check("t3_b2b_memread", mem_memread, 1);
    check("t3_b2b_addr", mem_addr, 32'h2008);
    check("t3_rvalid_one", aux_rvalid, 0);
    check("t3_rdata_hold", aux_rdata, 32'hAAAA0000);
    next_cycle();
    sample();
    check("t3_b2b_rvalid", aux_rvalid, 1);
    check("t3_b2b_rdata", aux_rdata, 32'h0BADF00D);
    next_cycle();

    // ---- 4: starvation limit forces aux in after 4 CPU grants
    clr_inputs();
    cpu_memread = 1; cpu_addr = 32'h1200;
    aux_valid = 1; aux_we = 0; aux_addr = 32'h4000;
    for (int i = 0; i < 4; i++) begin
      sample();
      check($sformatf("t4_cpu_grant%0d", i), mem_memread, 1);
      check($sformatf("t4_stall%0d", i), cpu_stall, 0);
      check($sformatf("t4_ready%0d", i), aux_ready, 0);
      next_cycle();
    end
    sample();
    check("t4_forced_ready", aux_ready, 1);
    check("t4_forced_stall", cpu_stall, 1);
    check("t4_forced_memread", mem_memread, 0);
    next_cycle();
    aux_valid = 0;
    sample();
    check("t4_acc_stall", cpu_stall, 1);
    check("t4_acc_addr", mem_addr, 32'h4000);
    next_cycle();
    sample();
    check("t4_rvalid", aux_rvalid, 1);
    check("t4_cpu_back_stall", cpu_stall, 0);
    check("t4_cpu_back_addr", mem_addr, 32'h1200);
    next_cycle();

    // ---- 5: aux read with mem_busy 2 cycles, CPU arrives during the access
    clr_inputs();
    aux_valid = 1; aux_we = 0; aux_addr = 32'h5000; aux_sign_mask = 3'b100;
    sample();
    check("t5_ready", aux_ready, 1);
    check("t5_stall0", cpu_stall, 1);
    next_cycle();
    aux_valid = 0; cpu_memread = 1; cpu_addr = 32'h1300;
    mem_busy = 1; mem_rdata = 32'h11111111;
    sample();
    check("t5_stall1", cpu_stall, 1);
    check("t5_addr1", mem_addr, 32'h5000);
    check("t5_mask1", {29'd0, mem_sign_mask}, 32'd4);
    next_cycle();
    mem_rdata = 32'h22222222;
    sample();
    check("t5_stall2", cpu_stall, 1);
    check("t5_rvalid2", aux_rvalid, 0);
    next_cycle();
    mem_busy = 0; mem_rdata = 32'h33333333;
    sample();
    check("t5_stall3", cpu_stall, 1);
    check("t5_memread3", mem_memread, 1);
    next_cycle();
    mem_rdata = 32'h44444444;
    sample();
    check("t5_rvalid", aux_rvalid, 1);
    check("t5_rdata", aux_rdata, 32'h33333333);
    check("t5_cpu_stall", cpu_stall, 0);
    check("t5_cpu_addr", mem_addr, 32'h1300);
    check("t5_cpu_rdata", cpu_rdata, 32'h44444444);
    next_cycle();
    cpu_memread = 0;
    sample();
    check("t5_rvalid_off", aux_rvalid, 0);
    check("t5_rdata_hold", aux_rdata, 32'h33333333);
    next_cycle();

    // ---- 6: reset in the middle of AUX_ACC
    clr_inputs();
    aux_valid = 1; aux_we = 1; aux_addr = 32'h6000;
    sample();
    check("t6_ready", aux_ready, 1);
    next_cycle();
    aux_valid = 0; mem_busy = 1; reset = 1;
    sample();
    check("t6_rst_memwrite", mem_memwrite, 0);
    check("t6_rst_stall", cpu_stall, 0);
    next_cycle();
    reset = 0; mem_busy = 0;
    for (int i = 0; i < 2; i++) begin
      sample();
      check($sformatf("t6_memwrite%0d", i), mem_memwrite, 0);
      check($sformatf("t6_memread%0d", i), mem_memread, 0);
      check($sformatf("t6_rvalid%0d", i), aux_rvalid, 0);
      check($sformatf("t6_stall%0d", i), cpu_stall, 0);
      next_cycle();
    end

    // ---- 7: reset clears a partially built starvation count
    clr_inputs();
    cpu_memread = 1; cpu_addr = 32'h1400; aux_valid = 1; aux_addr = 32'h7000;
    for (int i = 0; i < 3; i++) begin
      sample();
      check($sformatf("t7_pre_ready%0d", i), aux_ready, 0);
      next_cycle();
    end
    reset = 1;
    next_cycle();
    reset = 0;
    for (int i = 0; i < 4; i++) begin
      sample();
      check($sformatf("t7_ready%0d", i), aux_ready, 0);
      check($sformatf("t7_memread%0d", i), mem_memread, 1);
      next_cycle();
    end
    sample();
    check("t7_forced_ready", aux_ready, 1);
    next_cycle();
    clr_inputs();
    next_cycle();
    next_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
